// File: rtl/amp_i2c_target_pkg.sv
// Shared types and constants for the amp-config I2C target endpoint.
package amp_i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEV_ADR = 4'd1,
    ACK_DEV = 4'd2,
    REG_PTR = 4'd3,
    ACK_PTR = 4'd4,
    WR_BYTE = 4'd5,
    ACK_WR  = 4'd6,
    RD_BYTE = 4'd7,
    RD_ACK  = 4'd8
  } i2c_tgt_state_t;

  localparam logic [6:0] I2C_AMP_DEV_ADDR = 7'h20;

endpackage

// File: rtl/amp_i2c_target_line_sync.sv
// Synchronizes raw SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
module amp_i2c_target_line_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_LEN-1:0] scl_sync;
  logic [SYNC_LEN-1:0] sda_sync;
  logic                scl_prev;
  logic                sda_prev;
  logic                scl;

  // Lines idle high, so presetting to 1 keeps reset release from looking like an edge.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
      scl_sync <= {scl_sync[SYNC_LEN-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_LEN-2:0], sda_in};
      scl_prev <= scl_sync[SYNC_LEN-1];
      sda_prev <= sda_sync[SYNC_LEN-1];
    end
  end

  assign scl       = scl_sync[SYNC_LEN-1];
  assign sda       = sda_sync[SYNC_LEN-1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  // Both conditions require SCL high on both samples so an SCL edge is never mistaken for them.
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/amp_i2c_target.sv
// I2C target endpoint: device address match, register pointer, auto-incrementing write/read on an 8-bit register bus.
module amp_i2c_target
  import amp_i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_AMP_DEV_ADDR,
  parameter int         SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] status
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  amp_i2c_target_line_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk       (clk),
    .resetb    (resetb),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state;
  logic [2:0]     bit_cnt;
  logic           byte_full;
  logic [7:0]     shreg;
  logic           rw;
  logic           ack_bit;
  logic           receiving;

  assign receiving = (state == DEV_ADR) || (state == REG_PTR) || (state == WR_BYTE);
  assign status    = state;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      byte_full <= 1'b0;
      shreg     <= '0;
      rw        <= 1'b0;
      ack_bit   <= 1'b1;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state     <= DEV_ADR;
        bit_cnt   <= 3'd7;
        byte_full <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        // Incoming bits shift on the rise; the byte is acted on at the following fall so SDA moves with SCL low.
        if (receiving && scl_rise && !byte_full) begin
          shreg <= {shreg[6:0], sda};
          if (bit_cnt == 3'd0) byte_full <= 1'b1;
          else                 bit_cnt   <= bit_cnt - 3'd1;
        end
        case (state)
          DEV_ADR: if (scl_fall && byte_full) begin
            byte_full <= 1'b0;
            bit_cnt   <= 3'd7;
            if (shreg[7:1] == DEV_ADDR) begin
              state  <= ACK_DEV;
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= shreg[0];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          ACK_DEV: if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 3'd7;
            if (rw) begin
              reg_re <= 1'b1;
              state  <= RD_BYTE;
            end else begin
              state <= REG_PTR;
            end
          end
          REG_PTR: if (scl_fall && byte_full) begin
            byte_full <= 1'b0;
            bit_cnt   <= 3'd7;
            reg_addr  <= shreg;
            sda_oe    <= 1'b1;
            state     <= ACK_PTR;
          end
          ACK_PTR: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= WR_BYTE;
          end
          WR_BYTE: if (scl_fall && byte_full) begin
            byte_full <= 1'b0;
            bit_cnt   <= 3'd7;
            reg_wdata <= shreg;
            reg_we    <= 1'b1;
            sda_oe    <= 1'b1;
            state     <= ACK_WR;
          end
          ACK_WR: if (scl_fall) begin
            sda_oe   <= 1'b0;
            reg_addr <= reg_addr + 8'd1;
            state    <= WR_BYTE;
          end
          RD_BYTE: begin
            // reg_re is high exactly one clk after the request, which is when reg_rdata is valid.
            if (reg_re) begin
              shreg   <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= 3'd7;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) ack_bit <= sda;
            if (scl_fall) begin
              if (!ack_bit) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= 1'b1;
                state    <= RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                state  <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amp_i2c_target.sv
// Directed bench for amp_i2c_target: bit-banged I2C controller, register-bus monitor, vector table plus corner sequences.
module tb_amp_i2c_target;
  import amp_i2c_target_pkg::*;

  logic       clk = 1'b0;
  logic       resetb;
  logic       scl_drv, sda_drv, sda_bus;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0] status;

  always #5 clk = ~clk;

  assign sda_bus   = sda_drv & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'hA5;

  amp_i2c_target dut (
    .clk       (clk),
    .resetb    (resetb),
    .scl_in    (scl_drv),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .status    (status)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-bus and SDA monitor
  int          we_cnt, re_cnt, both_err, glitch_cnt;
  logic        oe_seen, busy_seen, prev_oe;
  logic [15:0] we_q[$];

  initial begin
    we_cnt = 0; re_cnt = 0; both_err = 0; glitch_cnt = 0;
    oe_seen = 1'b0; busy_seen = 1'b0; prev_oe = 1'b0;
  end

  always @(negedge clk) begin
    if (resetb === 1'b1) begin
      if (reg_we) begin
        we_cnt++;
        we_q.push_back({reg_addr, reg_wdata});
      end
      if (reg_re) re_cnt++;
      if (reg_we && reg_re) both_err++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (scl_drv && (sda_oe !== prev_oe)) glitch_cnt++;
    end
    prev_oe = sda_oe;
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    we_cnt = 0; re_cnt = 0; we_q.delete();
    oe_seen = 1'b0; busy_seen = 1'b0;
  endtask

  // Bit-banged controller: one SCL period is four quarters of four clks
  task automatic q();
    repeat (4) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; q();
    scl_drv = 1'b1; q();
    sda_drv = 1'b0; q();
    scl_drv = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; q();
    scl_drv = 1'b1; q();
    sda_drv = 1'b1; q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_drv = b[7-i]; q();
      scl_drv = 1'b1;   q(); q();
      scl_drv = 1'b0;   q();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_drv = 1'b1; q();
    scl_drv = 1'b1; q();
    ack = sda_bus;  q();
    scl_drv = 1'b0; q();
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      sda_drv = 1'b1; q();
      scl_drv = 1'b1; q();
      r = {r[6:0], sda_bus}; q();
      scl_drv = 1'b0; q();
    end
    sda_drv = ack;  q();
    scl_drv = 1'b1; q(); q();
    scl_drv = 1'b0; q();
    b = r;
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    int         exp_we;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
  } wr_vec_t;

  wr_vec_t vecs[8];

  initial begin
    logic        a;
    logic [7:0]  b0, b1;
    logic [7:0]  bytes[3];
    logic [15:0] entry;
    logic [15:0] burst_exp[3];

    vecs[0] = '{8'h40, 8'h18, 8'h35, 1'b0, 1, 8'h18, 8'h35};
    vecs[1] = '{8'h40, 8'h40, 8'h18, 1'b0, 1, 8'h40, 8'h18};
    vecs[2] = '{8'h40, 8'h35, 8'h08, 1'b0, 1, 8'h35, 8'h08};
    vecs[3] = '{8'h40, 8'h00, 8'hFF, 1'b0, 1, 8'h00, 8'hFF};
    vecs[4] = '{8'h40, 8'hFF, 8'h00, 1'b0, 1, 8'hFF, 8'h00};
    vecs[5] = '{8'h42, 8'h18, 8'h35, 1'b1, 0, 8'h00, 8'h00};
    vecs[6] = '{8'hC0, 8'h10, 8'h20, 1'b1, 0, 8'h00, 8'h00};
    vecs[7] = '{8'h21, 8'h55, 8'hAA, 1'b1, 0, 8'h00, 8'h00};
    burst_exp[0] = 16'hFE11;
    burst_exp[1] = 16'hFF22;
    burst_exp[2] = 16'h0033;

    resetb = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_status", status, 32'(IDLE));
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_busy", busy, 0);
    resetb = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte writes, including wrong/read-bit addresses that must stay silent
    for (int v = 0; v < 8; v++) begin
      clear_mon();
      bytes[0] = vecs[v].dev; bytes[1] = vecs[v].ptr; bytes[2] = vecs[v].data;
      i2c_start();
      for (int k = 0; k < 3; k++) begin
        send_byte(bytes[k], a);
        check($sformatf("v%0d_ack%0d", v, k), a, vecs[v].exp_ack);
        if (k == 0) check($sformatf("v%0d_busy_mid", v), busy, !vecs[v].exp_ack);
      end
      i2c_stop(); q();
      check($sformatf("v%0d_we_cnt", v), we_cnt, vecs[v].exp_we);
      check($sformatf("v%0d_re_cnt", v), re_cnt, 0);
      if (vecs[v].exp_we == 1) begin
        entry = (we_q.size() > 0) ? we_q.pop_front() : 16'hxxxx;
        check($sformatf("v%0d_wr_addr", v), entry[15:8], vecs[v].exp_addr);
        check($sformatf("v%0d_wr_data", v), entry[7:0], vecs[v].exp_wdata);
      end else begin
        check($sformatf("v%0d_oe_seen", v), oe_seen, 0);
        check($sformatf("v%0d_busy_seen", v), busy_seen, 0);
      end
      check($sformatf("v%0d_busy_end", v), busy, 0);
      check($sformatf("v%0d_status_end", v), status, 32'(IDLE));
    end

    // Burst write with pointer wrap 0xFF -> 0x00
    clear_mon();
    i2c_start();
    send_byte(8'h40, a); check("burst_ack_dev", a, 0);
    send_byte(8'hFE, a); check("burst_ack_ptr", a, 0);
    send_byte(8'h11, a); check("burst_ack_d0", a, 0);
    send_byte(8'h22, a); check("burst_ack_d1", a, 0);
    send_byte(8'h33, a); check("burst_ack_d2", a, 0);
    i2c_stop(); q();
    check("burst_we_cnt", we_cnt, 3);
    for (int k = 0; k < 3; k++) begin
      entry = (we_q.size() > 0) ? we_q.pop_front() : 16'hxxxx;
      check($sformatf("burst_wr%0d", k), entry, burst_exp[k]);
    end

    // Pointer set, repeated START, two-byte read ended with NACK
    clear_mon();
    i2c_start();
    send_byte(8'h40, a); check("rd_ack_dev_w", a, 0);
    send_byte(8'h10, a); check("rd_ack_ptr", a, 0);
    i2c_start();
    send_byte(8'h41, a); check("rd_ack_dev_r", a, 0);
    read_byte(b0, 1'b0);
    read_byte(b1, 1'b1);
    check("rd_byte0", b0, 8'hB5);
    check("rd_byte1", b1, 8'hB4);
    check("rd_nack_status", status, 32'(IDLE));
    check("rd_nack_sda_oe", sda_oe, 0);
    check("rd_nack_busy", busy, 0);
    i2c_stop(); q();
    check("rd_re_cnt", re_cnt, 2);
    check("rd_we_cnt", we_cnt, 0);

    // STOP in the middle of a data byte
    clear_mon();
    i2c_start();
    send_byte(8'h40, a); check("abort_ack_dev", a, 0);
    send_byte(8'h18, a); check("abort_ack_ptr", a, 0);
    send_bits(8'hA0, 4);
    i2c_stop(); q();
    check("abort_stop_status", status, 32'(IDLE));
    check("abort_stop_we", we_cnt, 0);
    check("abort_stop_busy", busy, 0);

    // Reset while the target is acknowledging a written byte
    clear_mon();
    i2c_start();
    send_byte(8'h40, a);
    send_byte(8'h18, a);
    send_bits(8'h77, 8);
    check("rstack_state", status, 32'(ACK_WR));
    check("rstack_sda_oe_before", sda_oe, 1);
    check("rstack_we_cnt", we_cnt, 1);
    resetb = 1'b0;
    @(posedge clk); #1;
    check("rstack_sda_oe_after", sda_oe, 0);
    check("rstack_status_after", status, 32'(IDLE));
    check("rstack_busy_after", busy, 0);
    check("rstack_addr_after", reg_addr, 0);
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    q();
    scl_drv = 1'b1; q();
    sda_drv = 1'b1; q();

    check("never_we_and_re", both_err, 0);
    check("sda_change_scl_high", glitch_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
